// File: rtl/seq_num_pkg.sv
// Shared types and constants for the sequence-number formatter.
package seq_num_pkg;

  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] NL    = 8'h0A;
  localparam logic [7:0] QMARK = 8'h3F;

  localparam int ENTRY_W = 5;

  // One queued number: end-of-line flag above the 4-bit value.
  typedef struct packed {
    logic       eol;
    logic [3:0] num;
  } entry_t;

  // Formatter FSM: which character is currently on the output register.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIGIT,
    ST_SEP,
    ST_EOL
  } state_t;

  // Decimal digits map to ASCII; anything above 9 is printed as '?'.
  function automatic logic [7:0] num_to_char(input logic [3:0] num);
    if (num <= 4'd9) begin
      return ZERO + {4'h0, num};
    end
    return QMARK;
  endfunction

endpackage

// File: rtl/seq_num_fifo.sv
// Synchronous FIFO holding queued {eol, num} entries between generator and formatter.
module seq_num_fifo
  import seq_num_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [ENTRY_W-1:0] din,
  input  logic               pop,
  output logic [ENTRY_W-1:0] dout,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               do_push;
  logic               do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Advance the read and write pointers on accepted transfers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Write storage for an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: storage is left unreset; the pointers alone decide which words are valid.
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/seq_num_formatter.sv
// Turns a stream of {num, eol} transfers into ASCII digits, separators and newlines.
module seq_num_formatter
  import seq_num_pkg::*;
#(
  parameter int         DEPTH = 4,
  parameter logic [7:0] SEP   = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_num,
  input  logic       in_eol,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_char,
  output logic [7:0] lines_done,
  output logic       bad_num
);

  state_t             state;
  state_t             state_next;
  logic [7:0]         char_next;
  logic               valid_next;
  logic               cur_eol;
  logic               eol_next;
  logic               pop;
  logic               nl_xfer;
  logic               push;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] fifo_dout;
  entry_t             head;

  // in_ready comes straight from registered pointer state, so reset clears it at once.
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign head     = entry_t'(fifo_dout);

  seq_num_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({in_eol, in_num}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  // Next state and next output character; pops the FIFO whenever a digit is loaded.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_next = state;
    char_next  = out_char;
    valid_next = out_valid;
    eol_next   = cur_eol;
    pop        = 1'b0;
    nl_xfer    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          valid_next = 1'b1;
          char_next  = num_to_char(head.num);
          eol_next   = head.eol;
          state_next = ST_DIGIT;
        end
      end
      ST_DIGIT: begin
        if (out_ready) begin
          if (cur_eol) begin
            char_next  = NL;
            state_next = ST_EOL;
          end else begin
            char_next  = SEP;
            state_next = ST_SEP;
          end
        end
      end
      ST_SEP, ST_EOL: begin
        if (out_ready) begin
          nl_xfer = (state == ST_EOL);
          if (!empty) begin
            // Back-to-back: next digit follows the separator with no bubble.
            pop        = 1'b1;
            char_next  = num_to_char(head.num);
            eol_next   = head.eol;
            state_next = ST_DIGIT;
          end else begin
            valid_next = 1'b0;
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        valid_next = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered output character.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      cur_eol   <= 1'b0;
    end else begin
      state     <= state_next;
      out_valid <= valid_next;
      out_char  <= char_next;
      cur_eol   <= eol_next;
    end
  end

  // Count newline handshakes; the 8-bit counter wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lines_done <= 8'd0;
    end else if (nl_xfer) begin
      lines_done <= lines_done + 8'd1;
    end
  end

  // Sticky flag for an accepted out-of-range number.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bad_num <= 1'b0;
    end else if (push && (in_num > 4'd9)) begin
      bad_num <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_num_formatter.sv
// Self-checking bench for seq_num_formatter: vector table, hand sequences, random scoreboard.
module tb_seq_num_formatter;

  localparam int         TB_DEPTH = 4;
  localparam logic [7:0] TB_SEP   = 8'h20;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_num;
  logic       in_eol;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_char;
  logic [7:0] lines_done;
  logic       bad_num;

  int total = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: expected character stream, newline count and bad flag.
  byte unsigned exp_q[$];
  byte unsigned txt[$];
  int           stamp[$];
  int           m_lines = 0;
  bit           m_bad   = 0;

  typedef struct {
    logic [3:0]   num;
    logic         eol;
    byte unsigned c0;
    byte unsigned c1;
  } vec_t;

  seq_num_formatter #(
    .DEPTH (TB_DEPTH),
    .SEP   (TB_SEP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_num     (in_num),
    .in_eol     (in_eol),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_char   (out_char),
    .lines_done (lines_done),
    .bad_num    (bad_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic byte unsigned char_of(input logic [3:0] n);
    return (n < 10) ? byte'(48 + n) : 8'h3F;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    txt.delete();
    stamp.delete();
    m_lines = 0;
    m_bad   = 0;
  endtask

  // Scoreboard: sampled on the falling edge, between input changes and the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(char_of(in_num));
        exp_q.push_back(in_eol ? 8'h0A : TB_SEP);
        if (in_num > 9) m_bad = 1;
      end
      if (out_valid && out_ready) begin
        txt.push_back(out_char);
        stamp.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++;
          n_bad++;
          $display("FAIL sb_extra: got=%0h want=none", out_char);
        end else begin
          byte unsigned e;
          e = exp_q.pop_front();
          check("sb_char", out_char, e);
          if (e == 8'h0A) m_lines++;
        end
      end
    end
  end

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b1;
    #3;
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic push(input logic [3:0] n, input logic e);
    int k = 0;
    in_valid = 1'b1;
    in_num   = n;
    in_eol   = e;
    @(negedge clk);
    while (!in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("push_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_timeout", (k < 2000), 1);
  endtask

  initial begin
    vec_t  vecs[6];
    string s;
    int    acc;
    int    stable_bad;
    logic [3:0] n;

    in_valid  = 1'b0;
    in_num    = 4'd0;
    in_eol    = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset values.
    check("rst_out_valid", out_valid, 0);
    check("rst_out_char", out_char, 8'h00);
    check("rst_in_ready", in_ready, 1);
    check("rst_lines", lines_done, 0);
    check("rst_bad", bad_num, 0);
    reset = 1'b0;

    // Table: mapping, follow-up character and one-edge latency from push to digit.
    vecs = '{
      '{4'd0,  1'b1, 8'h30, 8'h0A},
      '{4'd9,  1'b0, 8'h39, 8'h20},
      '{4'd4,  1'b1, 8'h34, 8'h0A},
      '{4'd10, 1'b1, 8'h3F, 8'h0A},
      '{4'd15, 1'b0, 8'h3F, 8'h20},
      '{4'd7,  1'b0, 8'h37, 8'h20}
    };
    foreach (vecs[i]) begin
      txt.delete();
      push(vecs[i].num, vecs[i].eol);
      check("lat_pre_valid", out_valid, 0);
      @(posedge clk); #1;
      check("lat_valid", out_valid, 1);
      check("lat_char", out_char, vecs[i].c0);
      drain();
      check("vec_len", txt.size(), 2);
      check("vec_c0", txt[0], vecs[i].c0);
      check("vec_c1", txt[1], vecs[i].c1);
    end

    // Line "3 2 1\n" on consecutive cycles.
    do_reset();
    push(4'd3, 1'b0);
    push(4'd2, 1'b0);
    push(4'd1, 1'b1);
    drain();
    check("l321_len", txt.size(), 6);
    check("l321_c0", txt[0], 8'h33);
    check("l321_c5", txt[5], 8'h0A);
    check("l321_span", stamp[5] - stamp[0], 5);
    check("l321_lines", lines_done, 1);

    // Full generator pattern.
    do_reset();
    for (int top = 9; top >= 3; top -= 2)
      for (int v = top; v >= 1; v--)
        push(4'(v), (v == 1));
    drain();
    s = "9 8 7 6 5 4 3 2 1\n7 6 5 4 3 2 1\n5 4 3 2 1\n3 2 1\n";
    check("gen_len", txt.size(), s.len());
    for (int i = 0; i < s.len(); i++) check("gen_char", txt[i], s[i]);
    check("gen_lines", lines_done, 4);

    // Backpressure: digit held, FIFO fills to DEPTH, then in_ready drops.
    do_reset();
    out_ready = 1'b0;
    push(4'd7, 1'b0);
    @(posedge clk); #1;
    check("bp_digit", out_char, 8'h37);
    acc        = 0;
    stable_bad = 0;
    n          = 4'd1;
    in_valid   = 1'b1;
    in_num     = n;
    in_eol     = 1'b0;
    for (int c = 0; c < 20; c++) begin
      bit took;
      @(negedge clk);
      took = in_ready;
      if (!out_valid || out_char != 8'h37) stable_bad++;
      @(posedge clk); #1;
      if (took) begin
        acc++;
        n++;
        in_num = n;
      end
    end
    in_valid = 1'b0;
    check("bp_accepted", acc, TB_DEPTH);
    check("bp_in_ready", in_ready, 0);
    check("bp_stable", stable_bad, 0);
    drain();
    check("bp_len", txt.size(), 2 * (TB_DEPTH + 1));
    check("bp_last_digit", txt[2 * TB_DEPTH], char_of(4'(TB_DEPTH)));

    // Out-of-range number sets a sticky flag.
    do_reset();
    push(4'd12, 1'b1);
    drain();
    check("bad_c0", txt[0], 8'h3F);
    check("bad_c1", txt[1], 8'h0A);
    check("bad_set", bad_num, 1);
    push(4'd4, 1'b1);
    drain();
    check("bad_sticky", bad_num, 1);

    // Asynchronous reset while in SEP with 3 entries queued.
    do_reset();
    check("bad_cleared", bad_num, 0);
    out_ready = 1'b0;
    push(4'd8, 1'b0);
    push(4'd6, 1'b0);
    push(4'd5, 1'b0);
    push(4'd4, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("mid_sep_char", out_char, TB_SEP);
    check("mid_sep_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_char", out_char, 8'h00);
    model_clear();
    @(posedge clk); #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    push(4'd5, 1'b1);
    drain();
    check("arst_len", txt.size(), 2);
    check("arst_c0", txt[0], 8'h35);
    check("arst_c1", txt[1], 8'h0A);

    // 256 single-number lines wrap the newline counter.
    do_reset();
    for (int i = 0; i < 256; i++) push(4'($urandom_range(0, 9)), 1'b1);
    drain();
    check("wrap_lines", lines_done, 0);
    check("wrap_model", m_lines, 256);

    // Random traffic with random backpressure against the scoreboard.
    do_reset();
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 120; i++) begin
          push(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
      end
    join
    drain();
    check("rnd_lines", lines_done, 8'(m_lines % 256));
    check("rnd_bad", bad_num, m_bad);
    check("rnd_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_num_formatter.md
# seq_num_formatter

Downstream consumer of the descending-number sequence generator. It accepts one decimal number per transfer, tagged with an end-of-line flag, and turns the stream into ASCII characters: the digit, a separator between numbers, and a newline after the last number of a line. A small input FIFO absorbs bursts, so the generator can keep running while the character sink (UART transmitter or text log) stalls.

## Interface
Parameters:
- `DEPTH`, 4: input FIFO entries; power of two, at least 2.
- `SEP`, 8'h20: separator character emitted between numbers on one line.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears FIFO, FSM and counters.
- `in_valid`  in  1  upstream number is valid.
- `in_ready`  out  1  FIFO can accept an entry.
- `in_num`  in  4  number to print, 0..15.
- `in_eol`  in  1  this number is the last on its line.
- `out_valid`  out  1  `out_char` is valid.
- `out_ready`  in  1  sink accepts the character.
- `out_char`  out  8  ASCII character.
- `lines_done`  out  8  count of newlines transferred; wraps 255 to 0.
- `bad_num`  out  1  sticky flag, set when `in_num` > 9 is accepted.

## Operation
- Input push: `in_valid && in_ready` at an edge writes {`in_eol`, `in_num`} to the FIFO. `in_ready` = !full, taken from registered state. A full FIFO never accepts, even when a pop occurs in the same cycle.
- Character mapping: `in_num` 0..9 maps to 8'h30 + `in_num`. Values 10..15 map to 8'h3F ('?') and set `bad_num`.
- FSM states:
  - IDLE: `out_valid`=0. If the FIFO is non-empty, pop it, present the digit, and go to DIGIT.
  - DIGIT: hold the character until `out_valid && out_ready`. On that handshake, present 8'h0A and go to EOL if the entry's eol bit is set; otherwise present `SEP` and go to SEP.
  - SEP or EOL: hold the character until the handshake. On the handshake, if the FIFO is non-empty, pop it and present the next digit (DIGIT). Otherwise drop `out_valid` and go to IDLE. A newline handshake also increments `lines_done`.
- Output: `out_char` and `out_valid` are registered and stay stable while `out_valid && !out_ready`.
- Simultaneous push and pop: allowed whenever the FIFO is not full. Occupancy is unchanged.
- Reset mid-operation: any in-flight character is discarded and the FIFO is emptied. `out_valid`, `in_ready` and the counters take their reset values immediately, asynchronously.

## Timing
- Reset values: `out_valid`=0, `out_char`=8'h00, `in_ready`=1, `lines_done`=0, `bad_num`=0, FSM=IDLE, FIFO empty.
- Latency: an entry pushed at edge k into an empty FIFO, with the FSM in IDLE, produces its digit on `out_char`/`out_valid` after edge k+1.
- Throughput: one character per cycle while `out_ready`=1. There are no bubbles between a separator or newline and the following digit when data is queued.
- Backpressure: each number costs 2 output cycles, so `in_ready` falls once DEPTH entries are queued.

## Structure
- Shared package `seq_num_pkg` holds:
  - ASCII constants: ZERO 8'h30, NL 8'h0A, QMARK 8'h3F.
  - The FSM state enum: IDLE, DIGIT, SEP, EOL.
  - The FIFO entry width (5).
- Sub-module `seq_num_fifo`: synchronous FIFO, parameter DEPTH, 5-bit data, push/pop/full/empty. It uses the same clock and asynchronous active-high reset.

## Test plan
- Line "3,2,1" (eol on 1), `out_ready`=1 → `out_char` sequence 33,20,32,20,31,0A on consecutive cycles; `lines_done`=1.
- Full generator pattern (lines 9..1, 7..1, 5..1, 3..1) → text "9 8 7 6 5 4 3 2 1\n7 6 5 4 3 2 1\n5 4 3 2 1\n3 2 1\n"; `lines_done`=4.
- Hold `out_ready`=0 for 20 cycles while pushing → exactly DEPTH entries accepted, then `in_ready`=0 and `out_char` stable. Release → no loss, order preserved.
- Push `in_num`=12 with eol → characters 3F,0A; `bad_num`=1 and stays 1 until reset.
- Assert `reset` while in SEP with 3 entries queued → `out_valid`=0 and `in_ready`=1 without waiting for a clock edge. The next pushed 5 with eol yields 35,0A only.
- 256 single-number lines → `lines_done` wraps to 0.
